// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Fetch lookup is combinational; execute trains the table; flush sweeps every entry.
module branch_target_predictor #(
    parameter int ADDR_WIDTH    = 16,
    parameter int ENTRIES       = 16,
    parameter int COUNTER_WIDTH = 2,
    parameter int STAT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  predict_hit,
    output logic                  predict_taken,
    output logic [ADDR_WIDTH-1:0] predict_next_pc,
    input  logic                  update_en,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic                  update_taken,
    input  logic [ADDR_WIDTH-1:0] update_target,
    input  logic                  update_mispredict,
    input  logic                  flush,
    output logic                  busy,
    output logic [STAT_WIDTH-1:0] update_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);
    localparam int INDEX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS;

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX            = '1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_WEAK_TAKEN     = COUNTER_WIDTH'(1 << (COUNTER_WIDTH - 1));
    localparam logic [COUNTER_WIDTH-1:0] CNT_WEAK_NOT_TAKEN = COUNTER_WIDTH'((1 << (COUNTER_WIDTH - 1)) - 1);
    localparam logic [7:0]               LAST_PTR           = 8'(ENTRIES - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                 state_reg;
    logic [7:0]             clr_ptr_reg;
    logic                   busy_reg;
    logic [STAT_WIDTH-1:0]  update_count_reg;
    logic [STAT_WIDTH-1:0]  mispredict_count_reg;

    logic [ENTRIES-1:0]       valid_vec;
    logic [COUNTER_WIDTH-1:0] counter_arr [ENTRIES];
    logic [TAG_BITS-1:0]      tag_mem     [ENTRIES];
    logic [ADDR_WIDTH-1:0]    target_mem  [ENTRIES];

    logic [INDEX_BITS-1:0]    lookup_idx;
    logic [TAG_BITS-1:0]      lookup_tag;
    logic                     lookup_match;

    logic [INDEX_BITS-1:0]    upd_idx;
    logic [TAG_BITS-1:0]      upd_tag;
    logic                     upd_match;
    logic [COUNTER_WIDTH-1:0] upd_counter;
    logic [COUNTER_WIDTH-1:0] counter_next;
    logic                     update_accept;
    logic                     entry_write;
    logic                     target_write;

    assign lookup_idx = lookup_pc[INDEX_BITS-1:0];
    assign lookup_tag = lookup_pc[ADDR_WIDTH-1:INDEX_BITS];
    assign upd_idx    = update_pc[INDEX_BITS-1:0];
    assign upd_tag    = update_pc[ADDR_WIDTH-1:INDEX_BITS];

    // Fetch-side prediction; suppressed while the table is being swept.
    always_comb begin
        lookup_match    = valid_vec[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
        predict_hit     = lookup_match && !busy_reg;
        predict_taken   = predict_hit && counter_arr[lookup_idx][COUNTER_WIDTH-1];
        predict_next_pc = predict_taken ? target_mem[lookup_idx]
                                        : lookup_pc + ADDR_WIDTH'(1);
    end

    assign update_accept = update_en && !busy_reg;
    assign upd_match     = valid_vec[upd_idx] && (tag_mem[upd_idx] == upd_tag);
    assign upd_counter   = counter_arr[upd_idx];
    // A not-taken miss leaves the table alone; anything else writes the entry.
    assign entry_write   = update_accept && (upd_match || update_taken);
    assign target_write  = update_accept && update_taken;

    always_comb begin
        counter_next = CNT_WEAK_TAKEN;
        if (upd_match) begin
            if (update_taken) begin
                counter_next = (upd_counter == CNT_MAX) ? upd_counter : upd_counter + 1'b1;
            end else begin
                counter_next = (upd_counter == '0) ? upd_counter : upd_counter - 1'b1;
            end
        end
    end

    // Tag and target need no reset: they are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (target_write) begin
            tag_mem[upd_idx]    <= upd_tag;
            target_mem[upd_idx] <= update_target;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic                     valid_reg;
            logic [COUNTER_WIDTH-1:0] counter_reg;
            logic                     clear_sel;
            logic                     write_sel;

            assign clear_sel = (state_reg == CLEAR) && (clr_ptr_reg == 8'(gi));
            assign write_sel = entry_write && (upd_idx == INDEX_BITS'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg   <= 1'b0;
                    counter_reg <= CNT_WEAK_NOT_TAKEN;
                end else if (clear_sel) begin
                    valid_reg   <= 1'b0;
                    counter_reg <= CNT_WEAK_NOT_TAKEN;
                end else if (write_sel) begin
                    valid_reg   <= 1'b1;
                    counter_reg <= counter_next;
                end
            end

            assign valid_vec[gi]   = valid_reg;
            assign counter_arr[gi] = counter_reg;
        end
    endgenerate

    // Flush sequencer: one entry cleared per cycle; a new flush restarts the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            clr_ptr_reg <= 8'd0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (flush) begin
                        state_reg   <= CLEAR;
                        clr_ptr_reg <= 8'd0;
                        busy_reg    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (flush) begin
                        clr_ptr_reg <= 8'd0;
                    end else if (clr_ptr_reg == LAST_PTR) begin
                        state_reg   <= IDLE;
                        clr_ptr_reg <= 8'd0;
                        busy_reg    <= 1'b0;
                    end else begin
                        clr_ptr_reg <= clr_ptr_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    clr_ptr_reg <= 8'd0;
                    busy_reg    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else if (update_accept) begin
            if (update_count_reg != '1) begin
                update_count_reg <= update_count_reg + 1'b1;
            end
            if (update_mispredict && (mispredict_count_reg != '1)) begin
                mispredict_count_reg <= mispredict_count_reg + 1'b1;
            end
        end
    end

    assign busy             = busy_reg;
    assign update_count     = update_count_reg;
    assign mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed scenarios plus randomized traffic
// checked against an abstract table model.
`timescale 1ns/1ps
module tb_branch_target_predictor;
    localparam int AW       = 16;
    localparam int N        = 16;
    localparam int CW       = 2;
    localparam int SW       = 16;
    localparam int CNT_HALF = 1 << (CW - 1);
    localparam int CNT_MAX  = (1 << CW) - 1;
    localparam int STAT_MAX = (1 << SW) - 1;
    localparam int STAT_MAX_S = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] lookup_pc = '0;
    logic          update_en = 1'b0;
    logic [AW-1:0] update_pc = '0;
    logic          update_taken = 1'b0;
    logic [AW-1:0] update_target = '0;
    logic          update_mispredict = 1'b0;
    logic          flush = 1'b0;

    logic          predict_hit, predict_taken, busy;
    logic [AW-1:0] predict_next_pc;
    logic [SW-1:0] update_count, mispredict_count;

    logic          s_hit, s_taken, s_busy;
    logic [AW-1:0] s_next;
    logic [3:0]    s_update_count, s_mispredict_count;

    int checks = 0;
    int errors = 0;

    // Reference model: plain per-index records plus a remaining-sweep count.
    bit m_valid  [N];
    int m_tag    [N];
    int m_target [N];
    int m_cnt    [N];
    int m_clear_left;
    int m_upd, m_mis, m_upd_s, m_mis_s;

    always #5 clk = ~clk;

    branch_target_predictor #(
        .ADDR_WIDTH(AW), .ENTRIES(N), .COUNTER_WIDTH(CW), .STAT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc),
        .predict_hit(predict_hit), .predict_taken(predict_taken),
        .predict_next_pc(predict_next_pc), .update_en(update_en),
        .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .flush(flush), .busy(busy), .update_count(update_count),
        .mispredict_count(mispredict_count)
    );

    branch_target_predictor #(
        .ADDR_WIDTH(AW), .ENTRIES(N), .COUNTER_WIDTH(CW), .STAT_WIDTH(4)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc),
        .predict_hit(s_hit), .predict_taken(s_taken),
        .predict_next_pc(s_next), .update_en(update_en),
        .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .flush(flush), .busy(s_busy), .update_count(s_update_count),
        .mispredict_count(s_mispredict_count)
    );

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 0;
            m_cnt[i]    = CNT_HALF - 1;
        end
        m_clear_left = 0;
        m_upd = 0; m_mis = 0; m_upd_s = 0; m_mis_s = 0;
    endtask

    task automatic model_apply();
        int idx, tg;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (update_en && m_clear_left == 0) begin
            idx = int'(update_pc) % N;
            tg  = int'(update_pc) / N;
            if (m_valid[idx] && m_tag[idx] == tg) begin
                if (update_taken) begin
                    m_cnt[idx]    = (m_cnt[idx] + 1 > CNT_MAX) ? CNT_MAX : m_cnt[idx] + 1;
                    m_target[idx] = int'(update_target);
                end else begin
                    m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
                end
            end else if (update_taken) begin
                m_valid[idx]  = 1'b1;
                m_tag[idx]    = tg;
                m_target[idx] = int'(update_target);
                m_cnt[idx]    = CNT_HALF;
            end
            m_upd   = (m_upd < STAT_MAX) ? m_upd + 1 : m_upd;
            m_upd_s = (m_upd_s < STAT_MAX_S) ? m_upd_s + 1 : m_upd_s;
            if (update_mispredict) begin
                m_mis   = (m_mis < STAT_MAX) ? m_mis + 1 : m_mis;
                m_mis_s = (m_mis_s < STAT_MAX_S) ? m_mis_s + 1 : m_mis_s;
            end
        end
        // The whole table is unobservable while busy, so invalidating at
        // flush start is equivalent to the entry-by-entry sweep.
        if (m_clear_left > 0) begin
            m_clear_left = flush ? N : m_clear_left - 1;
        end else if (flush) begin
            m_clear_left = N;
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 1'b0;
                m_cnt[i]   = CNT_HALF - 1;
            end
        end
    endtask

    function automatic void exp_lookup(input int pc, output bit hit, output bit taken,
                                       output logic [AW-1:0] nxt);
        int idx, tg;
        idx   = pc % N;
        tg    = pc / N;
        hit   = (m_clear_left == 0) && m_valid[idx] && (m_tag[idx] == tg);
        taken = hit && (m_cnt[idx] >= CNT_HALF);
        nxt   = taken ? AW'(m_target[idx]) : AW'((pc + 1) % (1 << AW));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        model_apply();
    endtask

    task automatic do_update(input logic [AW-1:0] pc, input logic taken,
                             input logic [AW-1:0] target, input logic misp);
        update_en = 1'b1; update_pc = pc; update_taken = taken;
        update_target = target; update_mispredict = misp;
        tick();
        update_en = 1'b0;
        $display("update pc=%h taken=%0b target=%h misp=%0b", pc, taken, target, misp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; update_en = 1'b0; flush = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        lookup_pc = 16'h0040;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_in_reset: got %0b expected 0", busy); end
        checks++; if (predict_next_pc !== 16'h0041) begin errors++; $display("FAIL reset_next_in_reset: got %h expected 0041", predict_next_pc); end
        rst_n = 1'b1;
        model_reset();
        tick();
        checks++; if (predict_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0b expected 0", predict_hit); end
        checks++; if (predict_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %0b expected 0", predict_taken); end
        checks++; if (predict_next_pc !== 16'h0041) begin errors++; $display("FAIL reset_next: got %h expected 0041", predict_next_pc); end
        checks++; if (update_count !== 16'd0) begin errors++; $display("FAIL reset_update_count: got %0d expected 0", update_count); end
        checks++; if (mispredict_count !== 16'd0) begin errors++; $display("FAIL reset_mispredict_count: got %0d expected 0", mispredict_count); end
        lookup_pc = 16'hFFFF;
        #1;
        checks++; if (predict_next_pc !== 16'h0000) begin errors++; $display("FAIL reset_wrap_next: got %h expected 0000", predict_next_pc); end
    endtask

    task automatic test_alloc();
        lookup_pc = 16'h0123;
        update_en = 1'b1; update_pc = 16'h0123; update_taken = 1'b1;
        update_target = 16'h0200; update_mispredict = 1'b0;
        #1;
        checks++; if (predict_hit !== 1'b0) begin errors++; $display("FAIL alloc_before_hit: got %0b expected 0", predict_hit); end
        tick();
        update_en = 1'b0;
        #1;
        checks++; if (predict_hit !== 1'b1) begin errors++; $display("FAIL alloc_hit: got %0b expected 1", predict_hit); end
        checks++; if (predict_taken !== 1'b1) begin errors++; $display("FAIL alloc_taken: got %0b expected 1", predict_taken); end
        checks++; if (predict_next_pc !== 16'h0200) begin errors++; $display("FAIL alloc_next: got %h expected 0200", predict_next_pc); end
        checks++; if (update_count !== 16'd1) begin errors++; $display("FAIL alloc_update_count: got %0d expected 1", update_count); end
        lookup_pc = 16'h0133;
        #1;
        checks++; if (predict_hit !== 1'b0) begin errors++; $display("FAIL alias_hit: got %0b expected 0", predict_hit); end
        checks++; if (predict_next_pc !== 16'h0134) begin errors++; $display("FAIL alias_next: got %h expected 0134", predict_next_pc); end
    endtask

    task automatic test_training();
        do_update(16'h0123, 1'b0, 16'h0555, 1'b1);
        do_update(16'h0123, 1'b0, 16'h0555, 1'b0);
        lookup_pc = 16'h0123;
        #1;
        checks++; if (predict_hit !== 1'b1) begin errors++; $display("FAIL train_nt_hit: got %0b expected 1", predict_hit); end
        checks++; if (predict_taken !== 1'b0) begin errors++; $display("FAIL train_nt_taken: got %0b expected 0", predict_taken); end
        checks++; if (predict_next_pc !== 16'h0124) begin errors++; $display("FAIL train_nt_next: got %h expected 0124", predict_next_pc); end
        for (int i = 0; i < 4; i++) do_update(16'h0123, 1'b1, 16'h0300, 1'b0);
        #1;
        checks++; if (predict_next_pc !== 16'h0300) begin errors++; $display("FAIL train_sat_next: got %h expected 0300", predict_next_pc); end
        // Saturated at max, one not-taken must still predict taken, old target kept.
        do_update(16'h0123, 1'b0, 16'h0555, 1'b0);
        #1;
        checks++; if (predict_taken !== 1'b1) begin errors++; $display("FAIL train_sat_taken: got %0b expected 1", predict_taken); end
        checks++; if (predict_next_pc !== 16'h0300) begin errors++; $display("FAIL train_keep_target: got %h expected 0300", predict_next_pc); end
        do_update(16'h0123, 1'b0, 16'h0555, 1'b0);
        #1;
        checks++; if (predict_taken !== 1'b0) begin errors++; $display("FAIL train_weak_nt: got %0b expected 0", predict_taken); end
        do_update(16'h0456, 1'b0, 16'h0777, 1'b0);
        lookup_pc = 16'h0456;
        #1;
        checks++; if (predict_hit !== 1'b0) begin errors++; $display("FAIL nt_miss_alloc: got %0b expected 0", predict_hit); end
        checks++; if (update_count !== 16'd10) begin errors++; $display("FAIL train_update_count: got %0d expected 10", update_count); end
        checks++; if (mispredict_count !== 16'd1) begin errors++; $display("FAIL train_mispredict_count: got %0d expected 1", mispredict_count); end
    endtask

    task automatic test_same_cycle();
        lookup_pc = 16'h0123;
        update_en = 1'b1; update_pc = 16'h0123; update_taken = 1'b1;
        update_target = 16'h0300; update_mispredict = 1'b0;
        #1;
        checks++; if (predict_taken !== 1'b0) begin errors++; $display("FAIL same_old_taken: got %0b expected 0", predict_taken); end
        checks++; if (predict_next_pc !== 16'h0124) begin errors++; $display("FAIL same_old_next: got %h expected 0124", predict_next_pc); end
        tick();
        update_en = 1'b0;
        #1;
        checks++; if (predict_taken !== 1'b1) begin errors++; $display("FAIL same_new_taken: got %0b expected 1", predict_taken); end
        checks++; if (predict_next_pc !== 16'h0300) begin errors++; $display("FAIL same_new_next: got %h expected 0300", predict_next_pc); end
    endtask

    task automatic test_flush();
        int cycles;
        logic [SW-1:0] cnt_before;
        cnt_before = update_count;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_start: got %0b expected 1", busy); end
        cycles = 0;
        while (busy === 1'b1 && cycles < 64) begin
            lookup_pc = 16'h0123;
            update_en = 1'b1; update_pc = AW'($urandom); update_taken = 1'b1;
            update_target = AW'($urandom);
            #1;
            checks++; if (predict_hit !== 1'b0 || predict_next_pc !== 16'h0124) begin
                errors++; $display("FAIL flush_lookup_suppressed: got hit=%0b next=%h expected hit=0 next=0124", predict_hit, predict_next_pc);
            end
            cycles++;
            tick();
        end
        update_en = 1'b0;
        $display("flush busy cycles=%0d", cycles);
        checks++; if (cycles != N) begin errors++; $display("FAIL flush_busy_cycles: got %0d expected %0d", cycles, N); end
        #1;
        checks++; if (update_count !== cnt_before) begin errors++; $display("FAIL flush_drop_updates: got %0d expected %0d", update_count, cnt_before); end
        lookup_pc = 16'h0123;
        #1;
        checks++; if (predict_hit !== 1'b0) begin errors++; $display("FAIL flush_cleared_hit: got %0b expected 0", predict_hit); end
    endtask

    task automatic test_reset_mid_flush();
        do_update(16'h0123, 1'b1, 16'h0200, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (5) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midflush_busy: got %0b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midflush_reset_busy: got %0b expected 0", busy); end
        checks++; if (update_count !== 16'd0) begin errors++; $display("FAIL midflush_reset_count: got %0d expected 0", update_count); end
        tick();
        rst_n = 1'b1;
        tick();
        lookup_pc = 16'h0123;
        #1;
        checks++; if (busy !== 1'b0 || predict_hit !== 1'b0) begin
            errors++; $display("FAIL midflush_after: got busy=%0b hit=%0b expected busy=0 hit=0", busy, predict_hit);
        end
    endtask

    task automatic test_stat_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            update_en = 1'b1; update_pc = AW'($urandom); update_taken = 1'($urandom);
            update_target = AW'($urandom); update_mispredict = 1'b1;
            if (i == 0) begin
                #1;
                checks++; if (update_count !== 16'd0) begin errors++; $display("FAIL stat_not_yet: got %0d expected 0", update_count); end
            end
            tick();
            if (i == 0) begin
                checks++; if (update_count !== 16'd1) begin errors++; $display("FAIL stat_next_cycle: got %0d expected 1", update_count); end
            end
        end
        update_en = 1'b0;
        #1;
        $display("stat small upd=%0d mis=%0d wide upd=%0d mis=%0d", s_update_count, s_mispredict_count, update_count, mispredict_count);
        checks++; if (s_update_count !== 4'(m_upd_s)) begin errors++; $display("FAIL stat_small_update: got %0d expected %0d", s_update_count, m_upd_s); end
        checks++; if (s_mispredict_count !== 4'd15) begin errors++; $display("FAIL stat_small_mispredict: got %0d expected 15", s_mispredict_count); end
        checks++; if (update_count !== 16'd20) begin errors++; $display("FAIL stat_wide_update: got %0d expected 20", update_count); end
        checks++; if (mispredict_count !== SW'(m_mis)) begin errors++; $display("FAIL stat_wide_mispredict: got %0d expected %0d", mispredict_count, m_mis); end
    endtask

    task automatic test_random();
        bit e_hit, e_taken;
        logic [AW-1:0] e_next;
        do_reset();
        for (int t = 0; t < 300; t++) begin
            lookup_pc = ($urandom_range(0, 5) == 0) ? AW'(16'hFFF0 + $urandom_range(0, 15))
                                                   : AW'($urandom_range(0, 3) * N + $urandom_range(0, N - 1));
            update_en         = 1'($urandom);
            update_pc         = AW'($urandom_range(0, 3) * N + $urandom_range(0, N - 1));
            update_taken      = ($urandom_range(0, 2) != 0);
            update_target     = AW'($urandom);
            update_mispredict = 1'($urandom);
            flush             = ($urandom_range(0, 39) == 0);
            #1;
            exp_lookup(int'(lookup_pc), e_hit, e_taken, e_next);
            $display("txn %0d lookup=%h hit=%0b taken=%0b next=%h upd=%0b pc=%h tk=%0b flush=%0b busy=%0b",
                     t, lookup_pc, predict_hit, predict_taken, predict_next_pc,
                     update_en, update_pc, update_taken, flush, busy);
            checks++; if (predict_hit !== e_hit || predict_taken !== e_taken || predict_next_pc !== e_next) begin
                errors++; $display("FAIL rand_lookup t=%0d: got hit=%0b taken=%0b next=%h expected hit=%0b taken=%0b next=%h",
                                   t, predict_hit, predict_taken, predict_next_pc, e_hit, e_taken, e_next);
            end
            checks++; if (busy !== (m_clear_left > 0)) begin
                errors++; $display("FAIL rand_busy t=%0d: got %0b expected %0b", t, busy, m_clear_left > 0);
            end
            checks++; if (update_count !== SW'(m_upd) || mispredict_count !== SW'(m_mis)) begin
                errors++; $display("FAIL rand_stats t=%0d: got upd=%0d mis=%0d expected upd=%0d mis=%0d",
                                   t, update_count, mispredict_count, m_upd, m_mis);
            end
            tick();
        end
        update_en = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alloc();
        test_training();
        test_same_cycle();
        test_flush();
        test_reset_mid_flush();
        test_stat_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

- Parametrised branch predictor: a direct-mapped branch target buffer with per-entry saturating direction counters.
- Sits between fetch and execute in the pipelined core:
  - Fetch presents its PC each cycle and receives a predicted next PC in the same cycle.
  - Execute reports resolved branches to train the table.
- Adds features the fixed 16-bit predictor lacks:
  - configurable address width, depth and counter width;
  - a multi-cycle flush sequence;
  - saturating training/misprediction statistics.

## Interface

Parameters:
- ADDR_WIDTH, 16, PC and target width (word-addressed)
- ENTRIES, 16, table depth; power of two, 2..256; INDEX_BITS = log2(ENTRIES), TAG_BITS = ADDR_WIDTH - INDEX_BITS
- COUNTER_WIDTH, 2, direction counter width, 1..4
- STAT_WIDTH, 16, statistics counter width

Ports:
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous and active-low.
  - clk  input  1  clock; all state changes on rising edge
  - rst_n  input  1  asynchronous active-low reset
- Lookup (fetch side, combinational):
  - lookup_pc  input  ADDR_WIDTH  fetch PC
  - predict_hit  output  1  valid entry with matching tag
  - predict_taken  output  1  predict_hit AND counter MSB set
  - predict_next_pc  output  ADDR_WIDTH  stored target if predict_taken, else lookup_pc + 1 (mod 2^ADDR_WIDTH)
- Update (execute side):
  - update_en  input  1  resolved branch this cycle
  - update_pc  input  ADDR_WIDTH  PC of resolved branch
  - update_taken  input  1  actual direction
  - update_target  input  ADDR_WIDTH  actual target
  - update_mispredict  input  1  execute detected misprediction
- Flush and statistics:
  - flush  input  1  one-cycle request to invalidate table
  - busy  output  1  flush sequence in progress
  - update_count  output  STAT_WIDTH  accepted updates, saturating
  - mispredict_count  output  STAT_WIDTH  accepted updates with update_mispredict=1, saturating

## Operation

- Index = pc[INDEX_BITS-1:0]; tag = pc[ADDR_WIDTH-1:INDEX_BITS].
- Entry fields:
  - valid, 1 bit
  - tag, TAG_BITS
  - target, ADDR_WIDTH
  - counter, COUNTER_WIDTH
- Reset (asynchronous) values:
  - Table: all valid=0; counters = 2^(COUNTER_WIDTH-1) - 1 (weakly not-taken).
  - State: FSM = IDLE, busy=0, both stats=0.
  - Outputs: predict_hit=0, predict_taken=0, predict_next_pc=lookup_pc+1.
- Update accepted when update_en=1 and busy=0. Updates while busy are dropped and not counted.
- Update, tag hit (valid and tag equal):
  - counter +1 if taken, -1 if not taken, saturating at 2^COUNTER_WIDTH-1 and 0;
  - target <= update_target only if taken.
- Update, tag miss or invalid entry:
  - if taken, allocate: valid=1, tag, target, counter = 2^(COUNTER_WIDTH-1) (weakly taken);
  - if not taken, table unchanged.
- Statistics:
  - each accepted update increments update_count;
  - accepted updates with update_mispredict=1 also increment mispredict_count;
  - both hold at all-ones.
- FSM states IDLE, CLEAR; 8-bit clear index ptr.
  - IDLE, flush=1: go to CLEAR, ptr=0, busy=1 next cycle.
  - CLEAR: each cycle valid[ptr]=0 and counter[ptr] = weakly not-taken; ptr+1.
  - CLEAR, ptr = ENTRIES-1 and flush=0: clear last entry, go to IDLE.
  - CLEAR, flush=1: restart at ptr=0.
- While busy=1: predict_hit=0, predict_taken=0, predict_next_pc=lookup_pc+1.
- Statistics are not cleared by flush; only rst_n clears them.

## Timing

- Lookup is purely combinational from lookup_pc and table state: zero-cycle latency.
- A table update written at edge N is visible to lookups from cycle N onward.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update contents.
- Flush:
  - pulse sampled at edge N: busy=1 from N through N+ENTRIES;
  - busy=0 after edge N+ENTRIES;
  - total ENTRIES cycles of CLEAR.
- Stats registered: the increment appears the cycle after the accepted update.
- rst_n assertion mid-flush: immediate return to IDLE, busy=0, reset values.

## Test plan

- After reset, lookup_pc=0x0040 -> predict_hit=0, predict_taken=0, predict_next_pc=0x0041; update_count=0.
- Allocation:
  - stimulus: update pc=0x0123, taken=1, target=0x0200;
  - next cycle lookup 0x0123 -> hit=1, taken=1, next_pc=0x0200;
  - lookup 0x0133 (same index, tag differs) -> hit=0, next_pc=0x0134.
- Counter training:
  - two not-taken updates to 0x0123 -> counter 2->1->0; lookup -> hit=1, taken=0, next_pc=0x0124;
  - four further taken updates -> counter saturates at 3.
- Flush:
  - stimulus: flush pulse with ENTRIES=16;
  - busy=1 for exactly 16 cycles; updates during busy leave update_count unchanged;
  - afterwards lookup 0x0123 -> hit=0.
- Statistics saturation: STAT_WIDTH=4, 20 accepted updates with mispredict=1 -> both counts = 15.
- Same-cycle lookup/update and reset:
  - same-cycle update/lookup of 0x0123 -> old prediction that cycle, new the next cycle;
  - rst_n low mid-flush -> busy=0 immediately.
